// File: rtl/rocev2_axis_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module  : rocev2_axis_pkt_fifo
// Brief   : Parametrised AXI-Stream packet FIFO for the RoCEv2 core data
//           ports. Cut-through or store-and-forward, null-beat dropping,
//           TSTRB regenerated from TKEEP, registered output head.
//           Optional statistics enabled by ROCEV2_AXIS_FIFO_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module rocev2_axis_pkt_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 16,
  parameter int STORE_FWD  = 0,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   s_axis_TDATA,
  input  logic [KEEP_WIDTH-1:0]   s_axis_TKEEP,
  input  logic                    s_axis_TLAST,
  input  logic                    s_axis_TVALID,
  output logic                    s_axis_TREADY,
  output logic [DATA_WIDTH-1:0]   m_axis_TDATA,
  output logic [KEEP_WIDTH-1:0]   m_axis_TKEEP,
  output logic [KEEP_WIDTH-1:0]   m_axis_TSTRB,
  output logic                    m_axis_TLAST,
  output logic                    m_axis_TVALID,
  input  logic                    m_axis_TREADY,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic [CNT_WIDTH-1:0]    drop_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

  // HOLD: normal store-and-forward gating; RELEASE: oversize packet drains
  typedef enum logic [0:0] {
    SF_HOLD    = 1'b0,
    SF_RELEASE = 1'b1
  } sf_state_t;

  // Storage
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [KEEP_WIDTH-1:0] r_mem_keep [DEPTH];
  logic                  r_mem_last [DEPTH];

  // Control state
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_LW-1:0]       r_level;
  logic [c_LW-1:0]       r_pkt_cnt;
  sf_state_t             r_state;
  logic                  r_s_ready;

  // Registered output head
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [KEEP_WIDTH-1:0] r_m_keep;
  logic                  r_m_last;

  // Combinational next-state
  logic                  w_wr_hs;
  logic                  w_null;
  logic                  w_store;
  logic                  w_rd;
  logic                  w_rd_last;
  logic [c_AW-1:0]       w_wr_ptr_nxt;
  logic [c_AW-1:0]       w_rd_ptr_nxt;
  logic [c_LW-1:0]       w_level_nxt;
  logic [c_LW-1:0]       w_pkt_cnt_nxt;
  logic [c_LW-1:0]       w_level_after_rd;
  sf_state_t             w_state_nxt;
  logic                  w_allow;
  logic                  w_m_valid_nxt;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [KEEP_WIDTH-1:0] w_head_keep;
  logic                  w_head_last;

  // A null beat is accepted but never stored; a beat during flush is lost.
  assign w_wr_hs   = s_axis_TVALID && r_s_ready;
  assign w_null    = (s_axis_TKEEP == '0) && !s_axis_TLAST;
  assign w_store   = w_wr_hs && !w_null && !flush;
  assign w_rd      = r_m_valid && m_axis_TREADY;
  assign w_rd_last = w_rd && r_m_last;

  // Pointer, occupancy and complete-packet bookkeeping for the next cycle
  always_comb begin
    w_wr_ptr_nxt  = '0;
    w_rd_ptr_nxt  = '0;
    w_level_nxt   = '0;
    w_pkt_cnt_nxt = '0;
    if (!flush) begin
      w_wr_ptr_nxt  = r_wr_ptr + c_AW'(w_store);
      w_rd_ptr_nxt  = r_rd_ptr + c_AW'(w_rd);
      w_level_nxt   = r_level + c_LW'(w_store) - c_LW'(w_rd);
      w_pkt_cnt_nxt = r_pkt_cnt + c_LW'(w_store && s_axis_TLAST) - c_LW'(w_rd_last);
    end
  end

  // Release mode lets a packet larger than the FIFO drain instead of deadlocking
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SF_HOLD: begin
        if ((STORE_FWD != 0) && (r_level == c_FULL) && (r_pkt_cnt == '0)) begin
          w_state_nxt = SF_RELEASE;
        end
      end
      SF_RELEASE: begin
        if (w_rd_last) begin
          w_state_nxt = SF_HOLD;
        end
      end
      default: w_state_nxt = SF_HOLD;
    endcase
    if (flush) begin
      w_state_nxt = SF_HOLD;
    end
  end

  // Select the next head entry; a beat written into an empty FIFO goes straight to the head register
  always_comb begin
    w_level_after_rd = r_level - c_LW'(w_rd);
    w_allow          = (STORE_FWD == 0) || (w_pkt_cnt_nxt != '0) || (w_state_nxt == SF_RELEASE);
    w_m_valid_nxt    = (w_level_nxt != '0) && w_allow;
    w_head_data      = '0;
    w_head_keep      = '0;
    w_head_last      = 1'b0;
    if (w_level_nxt == '0) begin
      w_head_data = '0;
      w_head_keep = '0;
      w_head_last = 1'b0;
    end else if (w_store && (w_level_after_rd == '0)) begin
      w_head_data = s_axis_TDATA;
      w_head_keep = s_axis_TKEEP;
      w_head_last = s_axis_TLAST;
    end else begin
      w_head_data = r_mem_data[w_rd_ptr_nxt];
      w_head_keep = r_mem_keep[w_rd_ptr_nxt];
      w_head_last = r_mem_last[w_rd_ptr_nxt];
    end
  end

  // Storage write; contents need no reset because occupancy qualifies every read
  always_ff @(posedge ap_clk) begin
    if (w_store) begin
      r_mem_data[r_wr_ptr] <= s_axis_TDATA;
      r_mem_keep[r_wr_ptr] <= s_axis_TKEEP;
      r_mem_last[r_wr_ptr] <= s_axis_TLAST;
    end
  end

  // Control state and registered output head
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_pkt_cnt <= '0;
      r_state   <= SF_HOLD;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_level   <= w_level_nxt;
      r_pkt_cnt <= w_pkt_cnt_nxt;
      r_state   <= w_state_nxt;
      r_s_ready <= (w_level_nxt != c_FULL);
      r_m_valid <= w_m_valid_nxt;
      r_m_data  <= w_head_data;
      r_m_keep  <= w_head_keep;
      r_m_last  <= w_head_last;
    end
  end

`ifdef ROCEV2_AXIS_FIFO_STATS_EN
  logic                 w_drop;
  logic [CNT_WIDTH-1:0] r_pkt_count;
  logic [CNT_WIDTH-1:0] r_drop_count;

  assign w_drop = w_wr_hs && w_null && !flush;

  // Saturating statistics; flush leaves them untouched
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_rd_last && (r_pkt_count != '1)) begin
        r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
      end
      if (w_drop && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + CNT_WIDTH'(1);
      end
    end
  end

  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif

  assign s_axis_TREADY = r_s_ready;
  assign m_axis_TVALID = r_m_valid;
  assign m_axis_TDATA  = r_m_data;
  assign m_axis_TKEEP  = r_m_keep;
  assign m_axis_TSTRB  = r_m_keep;
  assign m_axis_TLAST  = r_m_last;
  assign level         = r_level;

endmodule
`default_nettype wire

// File: tb/tb_rocev2_axis_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_rocev2_axis_pkt_fifo
// Brief   : Directed bench for rocev2_axis_pkt_fifo. Instance 0 is
//           cut-through, instance 1 store-and-forward; a scoreboard queue
//           per instance holds the beats expected at the output.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rocev2_axis_pkt_fifo;

  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int LW    = 5;
`ifdef ROCEV2_AXIS_FIFO_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [1:0]          flush, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [1:0][DW-1:0]  s_data, m_data;
  logic [1:0][KW-1:0]  s_keep, m_keep, m_strb;
  logic [1:0][LW-1:0]  lvl;
  logic [1:0][CW-1:0]  pkt, drop;

  int    errors = 0;
  int    checks = 0;
  int    nout [2];
  beat_t q0 [$];
  beat_t q1 [$];

  rocev2_axis_pkt_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH), .STORE_FWD(0), .CNT_WIDTH(CW)) u_dut_ct (
    .ap_clk(clk), .ap_rst_n(rst_n), .flush(flush[0]),
    .s_axis_TDATA(s_data[0]), .s_axis_TKEEP(s_keep[0]), .s_axis_TLAST(s_last[0]),
    .s_axis_TVALID(s_valid[0]), .s_axis_TREADY(s_ready[0]),
    .m_axis_TDATA(m_data[0]), .m_axis_TKEEP(m_keep[0]), .m_axis_TSTRB(m_strb[0]),
    .m_axis_TLAST(m_last[0]), .m_axis_TVALID(m_valid[0]), .m_axis_TREADY(m_ready[0]),
    .level(lvl[0]), .pkt_count(pkt[0]), .drop_count(drop[0])
  );

  rocev2_axis_pkt_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH), .STORE_FWD(1), .CNT_WIDTH(CW)) u_dut_sf (
    .ap_clk(clk), .ap_rst_n(rst_n), .flush(flush[1]),
    .s_axis_TDATA(s_data[1]), .s_axis_TKEEP(s_keep[1]), .s_axis_TLAST(s_last[1]),
    .s_axis_TVALID(s_valid[1]), .s_axis_TREADY(s_ready[1]),
    .m_axis_TDATA(m_data[1]), .m_axis_TKEEP(m_keep[1]), .m_axis_TSTRB(m_strb[1]),
    .m_axis_TLAST(m_last[1]), .m_axis_TVALID(m_valid[1]), .m_axis_TREADY(m_ready[1]),
    .level(lvl[1]), .pkt_count(pkt[1]), .drop_count(drop[1])
  );

  function automatic logic [CW-1:0] stat(input int n);
    return STATS_ON ? CW'(n) : '0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sb_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic sb_compare(input int d, input beat_t ob, input logic [KW-1:0] strb);
    beat_t e;
    checks++;
    assert (sb_size(d) != 0) else begin
      errors++;
      $error("FAIL sb_underflow: dut=%0d observed beat data=0x%0h with nothing expected", d, ob.d);
    end
    if (sb_size(d) != 0) begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk("out_data", 64'(ob.d), 64'(e.d));
      chk("out_keep", 64'(ob.k), 64'(e.k));
      chk("out_last", 64'(ob.l), 64'(e.l));
      chk("out_strb", 64'(strb), 64'(e.k));
    end
    nout[d]++;
  endtask

  // One clock: capture handshakes before the edge, score them 1 ns after it
  task automatic tick();
    logic [1:0]         w_hs, r_hs, fl;
    beat_t              in_b [2];
    beat_t              out_b [2];
    logic [1:0][KW-1:0] strb;
    for (int d = 0; d < 2; d++) begin
      w_hs[d]    = s_valid[d] & s_ready[d];
      r_hs[d]    = m_valid[d] & m_ready[d];
      fl[d]      = flush[d];
      in_b[d].d  = s_data[d];
      in_b[d].k  = s_keep[d];
      in_b[d].l  = s_last[d];
      out_b[d].d = m_data[d];
      out_b[d].k = m_keep[d];
      out_b[d].l = m_last[d];
      strb[d]    = m_strb[d];
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (r_hs[d]) sb_compare(d, out_b[d], strb[d]);
      if (fl[d]) begin
        if (d == 0) q0.delete(); else q1.delete();
      end else if (w_hs[d] && !((in_b[d].k == '0) && !in_b[d].l)) begin
        if (d == 0) q0.push_back(in_b[d]); else q1.push_back(in_b[d]);
      end
    end
  endtask

  // Present a beat and hold it until accepted; s_valid stays high afterwards
  task automatic send(input int d, input logic [DW-1:0] data, input logic [KW-1:0] keep, input logic last);
    logic hs;
    int   t;
    s_data[d]  = data;
    s_keep[d]  = keep;
    s_last[d]  = last;
    s_valid[d] = 1'b1;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < 60) begin
      hs = s_ready[d];
      tick();
      t++;
    end
    if (!hs) chk("send_timeout", 64'(t), 64'(0));
  endtask

  task automatic drain(input string tag, input int d, input int base, input int n);
    int t;
    t = 0;
    while ((nout[d] - base) < n && t < 100) begin
      tick();
      t++;
    end
    chk(tag, 64'(nout[d] - base), 64'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  base;
    int  acc;
    bit  seen_full;
    nout[0] = 0;
    nout[1] = 0;
    rst_n   = 1'b0;
    flush   = '0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    s_keep  = '0;
    m_ready = '0;

    // ---- reset values ----
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_s_ready", 64'(s_ready[d]), 64'(0));
      chk("rst_m_valid", 64'(m_valid[d]), 64'(0));
      chk("rst_m_last",  64'(m_last[d]),  64'(0));
      chk("rst_m_data",  64'(m_data[d]),  64'(0));
      chk("rst_m_strb",  64'(m_strb[d]),  64'(0));
      chk("rst_level",   64'(lvl[d]),     64'(0));
      chk("rst_pkt",     64'(pkt[d]),     64'(0));
      chk("rst_drop",    64'(drop[d]),    64'(0));
    end
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst0", 64'(s_ready[0]), 64'(1));
    chk("ready_after_rst1", 64'(s_ready[1]), 64'(1));

    // ---- cut-through 3-beat packet, one-cycle latency ----
    m_ready[0] = 1'b1;
    base = nout[0];
    for (int i = 0; i < 3; i++) begin
      send(0, DW'(32'h1000_0000 + i), '1, (i == 2));
      chk("t1_valid", 64'(m_valid[0]), 64'(1));
      chk("t1_head",  64'(m_data[0]),  64'(32'h1000_0000 + i));
    end
    s_valid[0] = 1'b0;
    drain("t1_count", 0, base, 3);
    chk("t1_pkt", 64'(pkt[0]), 64'(stat(1)));

    // ---- fill to DEPTH with output stalled, then drain in order ----
    m_ready[0] = 1'b0;
    acc = 0;
    for (int t = 0; t < 20; t++) begin
      logic pre;
      s_data[0]  = DW'(32'h2000_0000 + acc);
      s_keep[0]  = '1;
      s_last[0]  = (acc == 15);
      s_valid[0] = 1'b1;
      pre = s_ready[0];
      tick();
      if (pre) acc++;
    end
    s_valid[0] = 1'b0;
    chk("t2_accepted", 64'(acc), 64'(16));
    chk("t2_ready",    64'(s_ready[0]), 64'(0));
    chk("t2_level",    64'(lvl[0]), 64'(16));
    m_ready[0] = 1'b1;
    base = nout[0];
    drain("t2_count", 0, base, 16);
    tick();
    chk("t2_level_end", 64'(lvl[0]), 64'(0));
    chk("t2_sb_empty",  64'(sb_size(0)), 64'(0));
    chk("t2_pkt",       64'(pkt[0]), 64'(stat(2)));

    // ---- null beat dropped, empty-keep TLAST beat kept ----
    base = nout[0];
    send(0, 32'h3000_0000, 4'hF, 1'b0);
    send(0, 32'h3000_0001, 4'h0, 1'b0);
    send(0, 32'h3000_0002, 4'hF, 1'b0);
    send(0, 32'h3000_0003, 4'h3, 1'b1);
    send(0, 32'h3000_0004, 4'h0, 1'b1);
    s_valid[0] = 1'b0;
    drain("t3_count", 0, base, 4);
    chk("t3_drop", 64'(drop[0]), 64'(stat(1)));
    chk("t3_pkt",  64'(pkt[0]),  64'(stat(4)));

    // ---- store-and-forward: held until the TLAST beat is stored ----
    m_ready[1] = 1'b1;
    base = nout[1];
    for (int i = 0; i < 4; i++) begin
      send(1, DW'(32'h4000_0000 + i), '1, 1'b0);
      chk("t4_hold_beat", 64'(m_valid[1]), 64'(0));
    end
    s_valid[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_gap", 64'(m_valid[1]), 64'(0));
    end
    send(1, 32'h4000_0004, '1, 1'b1);
    s_valid[1] = 1'b0;
    chk("t4_release", 64'(m_valid[1]), 64'(1));
    chk("t4_head",    64'(m_data[1]),  64'(32'h4000_0000));
    drain("t4_count", 1, base, 5);

    // ---- store-and-forward oversize packet releases at full ----
    base = nout[1];
    seen_full = 1'b0;
    for (int i = 0; i < 24; i++) begin
      send(1, DW'(32'h5000_0000 + i), '1, (i == 23));
      if (lvl[1] == LW'(DEPTH)) seen_full = 1'b1;
      if (!seen_full) chk("t5_hold", 64'(m_valid[1]), 64'(0));
    end
    s_valid[1] = 1'b0;
    chk("t5_seen_full", 64'(seen_full), 64'(1));
    drain("t5_count", 1, base, 24);
    tick();
    chk("t5_level_end", 64'(lvl[1]), 64'(0));
    base = nout[1];
    send(1, 32'h5100_0000, '1, 1'b0);
    s_valid[1] = 1'b0;
    tick();
    chk("t5_back_to_sf", 64'(m_valid[1]), 64'(0));
    send(1, 32'h5100_0001, '1, 1'b1);
    s_valid[1] = 1'b0;
    drain("t5_after_count", 1, base, 2);

    // ---- flush mid-packet at level 7 ----
    m_ready[0] = 1'b0;
    for (int i = 0; i < 7; i++) send(0, DW'(32'h6000_0000 + i), '1, 1'b0);
    s_valid[0] = 1'b0;
    tick();
    chk("t6_level_pre", 64'(lvl[0]), 64'(7));
    s_data[0]  = 32'h6EEE_EEEE;
    s_keep[0]  = '1;
    s_last[0]  = 1'b1;
    s_valid[0] = 1'b1;
    flush[0]   = 1'b1;
    tick();
    flush[0]   = 1'b0;
    s_valid[0] = 1'b0;
    chk("t6_level",   64'(lvl[0]),     64'(0));
    chk("t6_valid",   64'(m_valid[0]), 64'(0));
    chk("t6_ready",   64'(s_ready[0]), 64'(1));
    chk("t6_pkt_hold", 64'(pkt[0]),    64'(stat(4)));
    m_ready[0] = 1'b1;
    base = nout[0];
    send(0, 32'h6100_0000, '1, 1'b0);
    send(0, 32'h6100_0001, '1, 1'b1);
    s_valid[0] = 1'b0;
    drain("t6_after_count", 0, base, 2);
    chk("t6_pkt_after", 64'(pkt[0]), 64'(stat(5)));

    // ---- asynchronous reset mid-packet ----
    m_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) send(0, DW'(32'h7000_0000 + i), '1, 1'b0);
    s_valid[0] = 1'b0;
    chk("t7_level_pre", 64'(lvl[0]), 64'(3));
    rst_n = 1'b0;
    #1;
    chk("t7_level", 64'(lvl[0]),     64'(0));
    chk("t7_valid", 64'(m_valid[0]), 64'(0));
    chk("t7_ready", 64'(s_ready[0]), 64'(0));
    chk("t7_pkt",   64'(pkt[0]),     64'(0));
    chk("t7_drop",  64'(drop[0]),    64'(0));
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t7_ready_after", 64'(s_ready[0]), 64'(1));
    m_ready[0] = 1'b1;
    base = nout[0];
    send(0, 32'h7100_0000, 4'h1, 1'b1);
    s_valid[0] = 1'b0;
    drain("t7_after_count", 0, base, 1);
    chk("t7_pkt_after", 64'(pkt[0]), 64'(stat(1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
